// File: rtl/bpu_pkg.sv
// Shared constants and counter helper for the branch prediction unit.
package bpu_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BGEZ = 3'b011;
    localparam logic [2:0] BR_BLEZ = 3'b100;
    localparam logic [2:0] BR_BGTZ = 3'b101;
    localparam logic [2:0] BR_BLTZ = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_J    = 2'b01;
    localparam logic [1:0] J_JR   = 2'b10;
    localparam logic [1:0] J_JALR = 2'b11;

    localparam logic [2:0] FL_NONE   = 3'b000;
    localparam logic [2:0] FL_JUMP   = 3'b110;
    localparam logic [2:0] FL_BRANCH = 3'b111;

    localparam logic [1:0] CTR_INIT  = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit counters: one combinational lookup port, one
// resolution write port. Writes land on the clock edge; no read bypass.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BTB_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_hit,
    output logic [1:0]      rd_ctr,
    output logic [PC_W-1:0] rd_target,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic [PC_W-1:0] wr_target
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [BTB_DEPTH-1:0]            valid_q;
    logic [BTB_DEPTH-1:0][TAG_W-1:0] tag_q;
    logic [BTB_DEPTH-1:0][PC_W-1:0]  tgt_q;
    logic [BTB_DEPTH-1:0][1:0]       ctr_q;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             wr_hit;
    logic             unused_lsb;

    assign rd_idx     = rd_pc[IDX_W+1:2];
    assign rd_tag     = rd_pc[PC_W-1:IDX_W+2];
    assign wr_idx     = wr_pc[IDX_W+1:2];
    assign wr_tag     = wr_pc[PC_W-1:IDX_W+2];
    assign unused_lsb = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = tgt_q[rd_idx];
    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) ctr_q[i] <= CTR_INIT;
        end else if (wr_en) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], wr_taken);
                if (wr_taken) tgt_q[wr_idx] <= wr_target;
            end else if (wr_taken) begin
                // Miss on a taken branch allocates, evicting any aliasing entry.
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= wr_target;
                ctr_q[wr_idx]   <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch/jump resolution and flush control. Define BPU_PREDICT_EN to build the
// BTB predictor; otherwise the unit behaves as static not-taken.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int BTB_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] IF_pc,
    output logic            IF_pred_taken,
    output logic [PC_W-1:0] IF_pred_target,
    input  logic [2:0]      Mem_Branch,
    input  logic            Mem_Zero,
    input  logic            Mem_Sign,
    input  logic [PC_W-1:0] Mem_pc,
    input  logic [PC_W-1:0] Mem_target,
    input  logic            Mem_pred_taken,
    input  logic            Mem_stall,
    input  logic [1:0]      Ex_jump,
    input  logic [PC_W-1:0] Ex_target,
    output logic            PC_flush,
    output logic            IF_ID_nop,
    output logic            ID_Ex_flush2,
    output logic [PC_W-1:0] redirect_pc
);
    logic       br_present, actual, mispredict;
    logic [2:0] flush;

    always_comb begin
        br_present = 1'b1;
        actual     = 1'b0;
        case (Mem_Branch)
            BR_BEQ:  actual = Mem_Zero;
            BR_BNE:  actual = ~Mem_Zero;
            BR_BGEZ: actual = ~Mem_Sign | Mem_Zero;
            BR_BLEZ: actual = Mem_Sign | Mem_Zero;
            BR_BGTZ: actual = ~Mem_Sign & ~Mem_Zero;
            BR_BLTZ: actual = Mem_Sign & ~Mem_Zero;
            default: br_present = 1'b0;
        endcase
    end

`ifdef BPU_PREDICT_EN
    logic            hit;
    logic [1:0]      ctr;
    logic [PC_W-1:0] target;

    bpu_btb #(.PC_W(PC_W), .BTB_DEPTH(BTB_DEPTH)) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (IF_pc),
        .rd_hit    (hit),
        .rd_ctr    (ctr),
        .rd_target (target),
        .wr_en     (br_present & ~Mem_stall),
        .wr_pc     (Mem_pc),
        .wr_taken  (actual),
        .wr_target (Mem_target)
    );

    assign IF_pred_taken  = hit & ctr[1];
    assign IF_pred_target = IF_pred_taken ? target : '0;
    assign mispredict     = br_present & (actual != Mem_pred_taken);
`else
    logic unused_static;

    // Static not-taken: only a taken branch disagrees with the implied prediction.
    assign unused_static  = ^{clk, IF_pc, Mem_pc, Mem_pred_taken, Mem_stall};
    assign IF_pred_taken  = 1'b0;
    assign IF_pred_target = '0;
    assign mispredict     = br_present & actual;
`endif

    // An older Mem-stage branch masks any Ex-stage jump, even when predicted right.
    always_comb begin
        flush       = FL_NONE;
        redirect_pc = '0;
        if (!rst_n) begin
            flush = FL_NONE;
        end else if (br_present) begin
            if (mispredict) begin
                flush       = FL_BRANCH;
                redirect_pc = actual ? Mem_target : Mem_pc + PC_W'(4);
            end
        end else if (Ex_jump != J_NONE) begin
            flush       = FL_JUMP;
            redirect_pc = Ex_target;
        end
    end

    assign {PC_flush, IF_ID_nop, ID_Ex_flush2} = flush;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized scoreboard bench for branch_predict_unit against an array-based
// reference model; follows BPU_PREDICT_EN the same way the design does.
module tb_branch_predict_unit;
    localparam int PC_W  = 32;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] IF_pc, IF_pred_target, Mem_pc, Mem_target, Ex_target, redirect_pc;
    logic            IF_pred_taken, Mem_Zero, Mem_Sign, Mem_pred_taken, Mem_stall;
    logic [2:0]      Mem_Branch;
    logic [1:0]      Ex_jump;
    logic            PC_flush, IF_ID_nop, ID_Ex_flush2;

    branch_predict_unit #(.PC_W(PC_W), .BTB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .IF_pc(IF_pc), .IF_pred_taken(IF_pred_taken),
        .IF_pred_target(IF_pred_target), .Mem_Branch(Mem_Branch), .Mem_Zero(Mem_Zero),
        .Mem_Sign(Mem_Sign), .Mem_pc(Mem_pc), .Mem_target(Mem_target),
        .Mem_pred_taken(Mem_pred_taken), .Mem_stall(Mem_stall), .Ex_jump(Ex_jump),
        .Ex_target(Ex_target), .PC_flush(PC_flush), .IF_ID_nop(IF_ID_nop),
        .ID_Ex_flush2(ID_Ex_flush2), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string     name;
        bit        pred;
        bit [31:0] ptgt;
        bit [2:0]  flush;
        bit [31:0] redir;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference BTB: entry per index, counter kept as a plain integer 0..3.
    bit        m_valid[DEPTH];
    bit [31:0] m_tag[DEPTH];
    bit [31:0] m_tgt[DEPTH];
    int        m_ctr[DEPTH];

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
    endfunction

    function automatic bit model_hit(bit [31:0] pc);
        int i = int'((pc / 4) % DEPTH);
        return m_valid[i] && m_tag[i] == pc / (4 * DEPTH);
    endfunction

    function automatic bit model_pred(bit [31:0] pc);
`ifdef BPU_PREDICT_EN
        return model_hit(pc) && m_ctr[(pc / 4) % DEPTH] >= 2;
`else
        return 0;
`endif
    endfunction

    function automatic bit outcome(int br, bit z, bit s);
        case (br)
            1: return z;
            2: return !z;
            3: return !s || z;
            4: return s || z;
            5: return !s && !z;
            6: return s && !z;
            default: return 0;
        endcase
    endfunction

    task automatic drive(string name, bit [31:0] ifpc, int br, bit z, bit s, bit [31:0] mpc,
                         bit [31:0] mt, bit mp, bit st, int ej, bit [31:0] et);
        exp_t e;
        bit present, act, mis;
        int i;
        @(posedge clk); #2;
        IF_pc = ifpc; Mem_Branch = 3'(br); Mem_Zero = z; Mem_Sign = s; Mem_pc = mpc;
        Mem_target = mt; Mem_pred_taken = mp; Mem_stall = st; Ex_jump = 2'(ej); Ex_target = et;
        present = br >= 1 && br <= 6;
        act = outcome(br, z, s);
`ifdef BPU_PREDICT_EN
        mis = present && act != mp;
`else
        mis = present && act;
`endif
        e.name = name;
        e.pred = model_pred(ifpc);
        e.ptgt = e.pred ? m_tgt[(ifpc / 4) % DEPTH] : 0;
        e.flush = 0; e.redir = 0;
        if (present) begin
            if (mis) begin e.flush = 3'b111; e.redir = act ? mt : mpc + 4; end
        end else if (ej != 0) begin
            e.flush = 3'b110; e.redir = et;
        end
        q.push_back(e);
        // Model the table write that the coming clock edge performs.
        if (present && !st) begin
            i = int'((mpc / 4) % DEPTH);
            if (model_hit(mpc)) begin
                m_ctr[i] = act ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
                if (act) m_tgt[i] = mt;
            end else if (act) begin
                m_valid[i] = 1; m_tag[i] = mpc / (4 * DEPTH); m_tgt[i] = mt; m_ctr[i] = 2;
            end
        end
    endtask

    task automatic push_zero(string name);
        exp_t e;
        e.name = name; e.pred = 0; e.ptgt = 0; e.flush = 0; e.redir = 0;
        q.push_back(e);
    endtask

    // Async reset mid-cycle with a flushing branch applied; outputs must stay 0.
    task automatic pulse_reset();
        @(posedge clk); #2;
        Mem_Branch = 3'b001; Mem_Zero = 1; Mem_pred_taken = 0; Ex_jump = 2'b11;
        rst_n = 0;
        model_clear();
        push_zero("in_reset");
        @(posedge clk); #2;
        Mem_Branch = 0; Ex_jump = 0;
        rst_n = 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (IF_pred_taken !== e.pred || IF_pred_target !== e.ptgt ||
                    {PC_flush, IF_ID_nop, ID_Ex_flush2} !== e.flush || redirect_pc !== e.redir) begin
                    failures++;
                    $display("FAIL %s: got pred=%b tgt=%h flush=%b redir=%h, want pred=%b tgt=%h flush=%b redir=%h",
                             e.name, IF_pred_taken, IF_pred_target, {PC_flush, IF_ID_nop, ID_Ex_flush2},
                             redirect_pc, e.pred, e.ptgt, e.flush, e.redir);
                end
            end
        end
    end

    bit [31:0] pool[8] = '{32'h100, 32'h200, 32'h104, 32'h180, 32'h300, 32'h1100, 32'hfffffffc, 32'h204};

    initial begin : stim
        int wait_cnt;
        rst_n = 0; IF_pc = 32'h100; Mem_Branch = 3'b001; Mem_Zero = 1; Mem_Sign = 0;
        Mem_pc = 32'h100; Mem_target = 32'h140; Mem_pred_taken = 0; Mem_stall = 0;
        Ex_jump = 2'b11; Ex_target = 32'h3000;
        model_clear();
        push_zero("reset_state");
        @(posedge clk); #2;
        Mem_Branch = 0; Ex_jump = 0;
        rst_n = 1;

        drive("lookup_cold", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("beq_alloc", 32'h100, 1, 1, 0, 32'h100, 32'h140, 0, 0, 0, 0);
        drive("lookup_hit", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("bne_t1", 32'h180, 2, 0, 0, 32'h180, 32'h1c0, 0, 0, 0, 0);
        drive("bne_t2", 32'h180, 2, 0, 0, 32'h180, 32'h1c0, 1, 0, 0, 0);
        drive("bne_t3", 32'h180, 2, 0, 0, 32'h180, 32'h1c0, 1, 0, 0, 0);
        drive("bne_nt", 32'h180, 2, 1, 0, 32'h180, 32'h1c0, 1, 0, 0, 0);
        drive("bne_after", 32'h180, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("bgez_nt_vs_jr", 32'h240, 3, 0, 1, 32'h240, 32'h400, 0, 0, 2, 32'h2000);
        drive("bgez_no_alloc", 32'h240, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("jalr", 32'h240, 0, 0, 0, 0, 0, 0, 0, 3, 32'h3000);
        drive("no_jump", 32'h240, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000);
        drive("rsvd_br", 32'h240, 7, 1, 1, 32'h240, 32'h500, 0, 0, 1, 32'h600);
        drive("alias_evict", 32'h100, 1, 1, 0, 32'h200, 32'h280, 0, 0, 0, 0);
        drive("alias_miss", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            drive("stall_hold", 32'h200, 1, 0, 0, 32'h200, 32'h280, 0, 1, 0, 0);
        drive("stall_release", 32'h200, 1, 0, 0, 32'h200, 32'h280, 0, 0, 0, 0);
        drive("after_stall", 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive("wrap_pc4", 32'h200, 1, 0, 0, 32'hfffffffc, 32'h10, 1, 0, 0, 0);
        pulse_reset();
        drive("post_reset", 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 1500; n++) begin
            bit [31:0] mpc;
            bit mp;
            if ($urandom_range(199) == 0) pulse_reset();
            mpc = pool[$urandom_range(7)];
            mp = $urandom_range(1) ? model_pred(mpc) : 1'($urandom_range(1));
            drive("rand", pool[$urandom_range(7)], $urandom_range(7), 1'($urandom_range(1)),
                  1'($urandom_range(1)), mpc, $urandom & 32'hfffffffc, mp,
                  $urandom_range(4) == 0, $urandom_range(3), $urandom & 32'hfffffffc);
        end

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 10) begin @(posedge clk); wait_cnt++; end
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
